// File: rtl/fpu_issue_ctrl_if.sv
// fpu_issue_ctrl_if: command, ALU and response signals between the issue
// controller (slave side) and its environment (master side).
interface fpu_issue_ctrl_if #(
  parameter int TAG_W = 4
);
  // Handshake rule for cmd_* and rsp_*: a transfer happens on a rising clock
  // edge where valid && ready are both high; while valid is high and ready is
  // low the sender keeps valid and its payload stable.
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_opcode;
  logic [31:0]      cmd_a;
  logic [31:0]      cmd_b;
  logic [TAG_W-1:0] cmd_tag;

  // ALU side: opcode 000 means "nothing in flight".
  logic [2:0]       alu_opcode;
  logic [31:0]      alu_op_a;
  logic [31:0]      alu_op_b;
  logic [31:0]      alu_result;
  logic             alu_exception;
  logic             alu_overflow;
  logic             alu_underflow;
  logic             alu_done;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_result;
  logic [TAG_W-1:0] rsp_tag;
  logic [4:0]       rsp_flags;

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_tag,
    output cmd_ready,
    output alu_opcode, alu_op_a, alu_op_b,
    input  alu_result, alu_exception, alu_overflow, alu_underflow, alu_done,
    output rsp_valid, rsp_result, rsp_tag, rsp_flags,
    input  rsp_ready
  );

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_tag,
    input  cmd_ready,
    input  alu_opcode, alu_op_a, alu_op_b,
    output alu_result, alu_exception, alu_overflow, alu_underflow, alu_done,
    input  rsp_valid, rsp_result, rsp_tag, rsp_flags,
    output rsp_ready
  );
endinterface

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: queues FP commands, issues them one at a time to the ALU,
// waits for its registered done (ignoring stale done right after issue),
// and returns result/tag/flags on a valid/ready response port.
module fpu_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  fpu_issue_ctrl_if.slave        bus,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic [1:0]             dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  typedef struct packed {
    logic [2:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  // Command FIFO storage and bookkeeping.
  cmd_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  cmd_t             head;

  // Issue FSM state, cycle counter, held command and captured response.
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cmd_t             hold_q;
  logic [31:0]      rsp_result_q, rsp_result_d;
  logic [4:0]       rsp_flags_q, rsp_flags_d;
  logic             head_legal;

  assign full       = (count_q == FULL_CNT);
  assign empty      = (count_q == '0);
  assign push       = bus.cmd_valid && !full;
  assign head       = mem_q[rd_ptr_q];
  assign head_legal = (head.op >= 3'd1) && (head.op <= 3'd5);

  // FIFO payload write; storage needs no reset since count_q gates reads.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= '{op: bus.cmd_opcode, a: bus.cmd_a, b: bus.cmd_b, tag: bus.cmd_tag};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
    end
  end

  // FSM state, counter, held command and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      hold_q       <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      if (pop) hold_q <= head;
    end
  end

  // Next-state logic: pop on issue, skip the ALU for illegal opcodes, ignore
  // done while settling, and let done win over a simultaneous timeout.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pop          = 1'b0;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop   = 1'b1;
          cnt_d = '0;
          if (head_legal) begin
            state_d = S_SETTLE;
          end else begin
            state_d      = S_RESP;
            rsp_result_d = '0;
            rsp_flags_d  = 5'b10000;
          end
        end
      end
      S_SETTLE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(SETTLE - 1)) state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (bus.alu_done) begin
          state_d      = S_RESP;
          rsp_result_d = bus.alu_result;
          rsp_flags_d  = {2'b00, bus.alu_underflow, bus.alu_overflow, bus.alu_exception};
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d      = S_RESP;
          rsp_result_d = '0;
          rsp_flags_d  = 5'b01000;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode: opcode reaches the ALU only while an op is in flight.
  always_comb begin
    bus.cmd_ready  = !full;
    bus.alu_opcode = ((state_q == S_SETTLE) || (state_q == S_WAIT)) ? hold_q.op : 3'b000;
    bus.alu_op_a   = hold_q.a;
    bus.alu_op_b   = hold_q.b;
    bus.rsp_valid  = (state_q == S_RESP);
    bus.rsp_result = rsp_result_q;
    bus.rsp_tag    = hold_q.tag;
    bus.rsp_flags  = rsp_flags_q;
    busy           = (state_q != S_IDLE);
    fifo_count     = count_q;
    dbg_state      = state_q;
  end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed bench for fpu_issue_ctrl with a stub ALU.
module tb_fpu_issue_ctrl;
  localparam int TAG_W = 4;

  // Clock and reset.
  logic       clk = 1'b0;
  logic       reset;
  logic       busy;
  logic [2:0] fifo_count;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  fpu_issue_ctrl_if #(.TAG_W(TAG_W)) bus_if ();

  fpu_issue_ctrl #(
    .DEPTH(4), .TAG_W(TAG_W), .SETTLE(2), .TIMEOUT(64)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus_if),
    .busy(busy),
    .fifo_count(fifo_count),
    .dbg_state(dbg_state)
  );

  // Stub ALU: registered done one cycle after a nonzero opcode appears.
  // stub_hang suppresses done; stub_force presents a stale done with junk data.
  logic stub_hang, stub_force, stub_done_q, stub_uf, stub_of, stub_exc;

  function automatic logic [31:0] stub_calc(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return a ^ b;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stub_done_q <= 1'b0;
    else       stub_done_q <= (bus_if.alu_opcode != 3'b000) && !stub_hang;
  end

  assign bus_if.alu_done      = stub_force | stub_done_q;
  assign bus_if.alu_result    = stub_force ? 32'hDEAD_BEEF : stub_calc(bus_if.alu_op_a, bus_if.alu_op_b);
  assign bus_if.alu_underflow = stub_uf;
  assign bus_if.alu_overflow  = stub_of;
  assign bus_if.alu_exception = stub_exc;

  // Scoreboard counters and observation flags.
  int   n_checks = 0;
  int   n_errors = 0;
  logic saw_opcode7;
  logic saw_rsp;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 ns after the next rising edge and record sticky observations.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus_if.alu_opcode == 3'b111) saw_opcode7 = 1'b1;
    if (bus_if.rsp_valid) saw_rsp = 1'b1;
  endtask

  // Offer one command and return 1 ns after the edge that accepts it.
  task automatic push(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [TAG_W-1:0] tag);
    int k;
    bus_if.cmd_valid  = 1'b1;
    bus_if.cmd_opcode = op;
    bus_if.cmd_a      = a;
    bus_if.cmd_b      = b;
    bus_if.cmd_tag    = tag;
    k = 0;
    while (!bus_if.cmd_ready && k < 200) begin
      tick();
      k++;
    end
    if (k >= 200) check_eq("push_timeout", 32'(k), 32'd0);
    tick();
    bus_if.cmd_valid = 1'b0;
  endtask

  // Count edges until rsp_valid is seen, bounded by max.
  task automatic wait_rsp(input int max, output int k);
    k = 0;
    while (!bus_if.rsp_valid && k < max) begin
      tick();
      k++;
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus.
  initial begin
    int k;
    reset             = 1'b1;
    bus_if.cmd_valid  = 1'b0;
    bus_if.cmd_opcode = 3'b000;
    bus_if.cmd_a      = '0;
    bus_if.cmd_b      = '0;
    bus_if.cmd_tag    = '0;
    bus_if.rsp_ready  = 1'b0;
    stub_hang = 1'b0; stub_force = 1'b0;
    stub_uf = 1'b0; stub_of = 1'b0; stub_exc = 1'b0;
    saw_opcode7 = 1'b0; saw_rsp = 1'b0;

    // Reset values.
    repeat (3) tick();
    check_eq("rst_rsp_valid",  32'(bus_if.rsp_valid),  32'd0);
    check_eq("rst_cmd_ready",  32'(bus_if.cmd_ready),  32'd1);
    check_eq("rst_alu_opcode", 32'(bus_if.alu_opcode), 32'd0);
    check_eq("rst_alu_op_a",   bus_if.alu_op_a,        32'd0);
    check_eq("rst_busy",       32'(busy),              32'd0);
    check_eq("rst_fifo_count", 32'(fifo_count),        32'd0);
    check_eq("rst_rsp_flags",  32'(bus_if.rsp_flags),  32'd0);
    check_eq("rst_state",      32'(dbg_state),         32'd0);
    reset = 1'b0;
    tick();

    // ADD 1.0 + 2.0, minimum latency.
    bus_if.rsp_ready = 1'b1;
    push(3'd1, 32'h3F80_0000, 32'h4000_0000, 4'd3);
    wait_rsp(20, k);
    check_eq("add_latency", 32'(k), 32'd4);
    check_eq("add_result",  bus_if.rsp_result, 32'h4040_0000);
    check_eq("add_tag",     32'(bus_if.rsp_tag), 32'd3);
    check_eq("add_flags",   32'(bus_if.rsp_flags), 32'd0);
    check_eq("add_busy",    32'(busy), 32'd1);
    check_eq("add_resp_opcode", 32'(bus_if.alu_opcode), 32'd0);
    tick();
    check_eq("add_valid_drop", 32'(bus_if.rsp_valid), 32'd0);
    check_eq("add_idle_busy",  32'(busy), 32'd0);

    // MUL with ALU underflow+exception flags.
    stub_uf = 1'b1; stub_exc = 1'b1;
    push(3'd3, 32'h1111_0000, 32'h0000_2222, 4'd7);
    wait_rsp(20, k);
    check_eq("mul_result", bus_if.rsp_result, 32'h1111_2222);
    check_eq("mul_flags",  32'(bus_if.rsp_flags), 32'h05);
    check_eq("mul_tag",    32'(bus_if.rsp_tag), 32'd7);
    tick();
    stub_uf = 1'b0; stub_exc = 1'b0;

    // Illegal opcode never reaches the ALU.
    saw_opcode7 = 1'b0;
    push(3'd7, 32'hAAAA_5555, 32'h1234_5678, 4'd9);
    wait_rsp(20, k);
    check_eq("ill_latency", 32'(k), 32'd1);
    check_eq("ill_flags",   32'(bus_if.rsp_flags), 32'h10);
    check_eq("ill_result",  bus_if.rsp_result, 32'd0);
    check_eq("ill_tag",     32'(bus_if.rsp_tag), 32'd9);
    tick();
    check_eq("ill_no_issue", 32'(saw_opcode7), 32'd0);

    // Five back-to-back commands with the response port stalled.
    bus_if.rsp_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      push(3'((i % 5) + 1), 32'(32'h100 * i), 32'(i), 4'(i));
    end
    check_eq("bp_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
    check_eq("bp_fifo_full", 32'(fifo_count), 32'd4);
    wait_rsp(20, k);
    check_eq("bp_first_tag", 32'(bus_if.rsp_tag), 32'd1);
    repeat (3) tick();
    check_eq("bp_hold_valid",  32'(bus_if.rsp_valid), 32'd1);
    check_eq("bp_hold_tag",    32'(bus_if.rsp_tag), 32'd1);
    check_eq("bp_hold_result", bus_if.rsp_result, 32'h0000_0101);
    check_eq("bp_hold_opcode", 32'(bus_if.alu_opcode), 32'd0);
    bus_if.rsp_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      wait_rsp(20, k);
      check_eq("bp_order_tag",    32'(bus_if.rsp_tag), 32'(i));
      check_eq("bp_order_result", bus_if.rsp_result, 32'(32'h100 * i) ^ 32'(i));
      tick();
    end
    check_eq("bp_drained_count", 32'(fifo_count), 32'd0);
    check_eq("bp_drained_ready", 32'(bus_if.cmd_ready), 32'd1);

    // ALU never answers: timeout after 64 SETTLE/WAIT cycles.
    stub_hang = 1'b1;
    push(3'd1, 32'h0F0F_0000, 32'h0000_00F0, 4'hA);
    wait_rsp(100, k);
    check_eq("to_latency", 32'(k), 32'd65);
    check_eq("to_flags",   32'(bus_if.rsp_flags), 32'h08);
    check_eq("to_result",  bus_if.rsp_result, 32'd0);
    check_eq("to_tag",     32'(bus_if.rsp_tag), 32'hA);
    tick();
    stub_hang = 1'b0;
    push(3'd2, 32'h00FF_0000, 32'h0000_FF00, 4'hB);
    wait_rsp(20, k);
    check_eq("after_to_latency", 32'(k), 32'd4);
    check_eq("after_to_result",  bus_if.rsp_result, 32'h00FF_FF00);
    check_eq("after_to_flags",   32'(bus_if.rsp_flags), 32'd0);
    tick();

    // Stale done held through SETTLE must not be captured.
    stub_force = 1'b1;
    push(3'd4, 32'h4080_0000, 32'h0000_0001, 4'hC);
    repeat (3) tick();
    stub_force = 1'b0;
    wait_rsp(20, k);
    check_eq("stale_latency", 32'(k), 32'd1);
    check_eq("stale_result",  bus_if.rsp_result, 32'h4080_0001);
    check_eq("stale_tag",     32'(bus_if.rsp_tag), 32'hC);
    tick();

    // Reset during WAIT of a DIV with two commands queued.
    stub_hang = 1'b1;
    bus_if.rsp_ready = 1'b0;
    push(3'd4, 32'h3F80_0000, 32'h4000_0000, 4'hD);
    push(3'd1, 32'h0000_0001, 32'h0000_0002, 4'hE);
    push(3'd2, 32'h0000_0003, 32'h0000_0004, 4'hF);
    repeat (2) tick();
    check_eq("mid_opcode", 32'(bus_if.alu_opcode), 32'd4);
    check_eq("mid_count",  32'(fifo_count), 32'd2);
    saw_rsp = 1'b0;
    #2 reset = 1'b1;
    #1;
    check_eq("arst_rsp_valid",  32'(bus_if.rsp_valid), 32'd0);
    check_eq("arst_alu_opcode", 32'(bus_if.alu_opcode), 32'd0);
    check_eq("arst_alu_op_a",   bus_if.alu_op_a, 32'd0);
    check_eq("arst_alu_op_b",   bus_if.alu_op_b, 32'd0);
    check_eq("arst_busy",       32'(busy), 32'd0);
    check_eq("arst_fifo_count", 32'(fifo_count), 32'd0);
    check_eq("arst_cmd_ready",  32'(bus_if.cmd_ready), 32'd1);
    check_eq("arst_rsp_result", bus_if.rsp_result, 32'd0);
    check_eq("arst_rsp_tag",    32'(bus_if.rsp_tag), 32'd0);
    check_eq("arst_rsp_flags",  32'(bus_if.rsp_flags), 32'd0);
    tick();
    reset = 1'b0;
    stub_hang = 1'b0;
    bus_if.rsp_ready = 1'b1;
    repeat (10) tick();
    check_eq("arst_no_rsp",     32'(saw_rsp), 32'd0);
    check_eq("arst_still_idle", 32'(busy), 32'd0);

    // Normal operation after reset.
    push(3'd1, 32'h3F80_0000, 32'h4000_0000, 4'd2);
    wait_rsp(20, k);
    check_eq("post_latency", 32'(k), 32'd4);
    check_eq("post_result",  bus_if.rsp_result, 32'h4040_0000);
    check_eq("post_tag",     32'(bus_if.rsp_tag), 32'd2);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
